// File: rtl/kmap_pkg.sv
// Shared constants and FSM state type for the K-map truth-table scanner.
package kmap_pkg;

    localparam int N_IN_DEF     = 4;
    localparam int MINTERMS_DEF = 2 ** N_IN_DEF;
    localparam int SETTLE_DEF   = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        APPLY  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/kmap_scanner_if.sv
// Stimulus/capture bundle between the scanner and its controller/function block.
interface kmap_scanner_if #(
    parameter int N_IN = kmap_pkg::N_IN_DEF
);
    localparam int MINTERMS = 2 ** N_IN;

    logic                start;
    logic [MINTERMS-1:0] expected;
    logic                f_in;
    logic [N_IN-1:0]     abcd_out;
    logic                busy;
    logic                done;
    logic [MINTERMS-1:0] truth;
    logic [N_IN:0]       ones_cnt;
    logic                match;

    modport master (
        output start, expected, f_in,
        input  abcd_out, busy, done, truth, ones_cnt, match
    );

    modport slave (
        input  start, expected, f_in,
        output abcd_out, busy, done, truth, ones_cnt, match
    );

endinterface

// File: rtl/kmap_settle_timer.sv
// Clear/enable settle counter; tc_o flags the last hold cycle (count == SETTLE-1).
module kmap_settle_timer #(
    parameter int SETTLE = kmap_pkg::SETTLE_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);
    localparam logic [3:0] TC_VAL = 4'(SETTLE - 1);

    logic [3:0] count_q;
    logic [3:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = (count_q == TC_VAL);

endmodule

// File: rtl/kmap_scanner.sv
// Walks minterms 0..MINTERMS-1 onto a K-map block, captures its truth table and compares it.
module kmap_scanner
    import kmap_pkg::*;
#(
    parameter int N_IN   = N_IN_DEF,
    parameter int SETTLE = SETTLE_DEF
) (
    input  logic           clk,
    input  logic           rst,
    kmap_scanner_if.slave  bus
);
    localparam int MINTERMS = 2 ** N_IN;
    localparam logic [N_IN-1:0] LAST_IDX = '1;

    state_e              state_q, state_d;
    logic [N_IN-1:0]     idx_q, idx_d;
    logic [N_IN-1:0]     abcd_q, abcd_d;
    logic [MINTERMS-1:0] truth_q, truth_d;
    logic [N_IN:0]       ones_q, ones_d;
    logic                match_q, match_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                tmr_clr, tmr_en, tmr_tc;

    kmap_settle_timer #(.SETTLE(SETTLE)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clr_i (tmr_clr),
        .en_i  (tmr_en),
        .tc_o  (tmr_tc)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        abcd_d  = abcd_q;
        truth_d = truth_q;
        ones_d  = ones_q;
        match_d = match_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        tmr_clr = 1'b0;
        tmr_en  = 1'b0;
        case (state_q)
            IDLE: begin
                tmr_clr = 1'b1;
                if (bus.start) begin
                    state_d = APPLY;
                    idx_d   = '0;
                    abcd_d  = '0;
                    truth_d = '0;
                    ones_d  = '0;
                    match_d = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            APPLY: begin
                tmr_en = 1'b1;
                if (tmr_tc) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                tmr_clr        = 1'b1;
                truth_d[idx_q] = bus.f_in;
                ones_d         = ones_q + (N_IN+1)'(bus.f_in);
                if (idx_q == LAST_IDX) begin
                    // match must include the sample being captured on this same edge
                    state_d = DONE;
                    done_d  = 1'b1;
                    match_d = (truth_d == bus.expected);
                end else begin
                    state_d = APPLY;
                    idx_d   = idx_q + 1'b1;
                    abcd_d  = abcd_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                abcd_d  = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            abcd_q  <= '0;
            truth_q <= '0;
            ones_q  <= '0;
            match_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            abcd_q  <= abcd_d;
            truth_q <= truth_d;
            ones_q  <= ones_d;
            match_q <= match_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.abcd_out = abcd_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.truth    = truth_q;
    assign bus.ones_cnt = ones_q;
    assign bus.match    = match_q;

endmodule

// File: tb/tb_kmap_scanner.sv
// Directed bench: two scanners (SETTLE=1 and SETTLE=3) driving modelled K-map blocks.
module tb_kmap_scanner;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    kmap_scanner_if #(.N_IN(4)) bus1 ();
    kmap_scanner_if #(.N_IN(4)) bus3 ();

    kmap_scanner #(.N_IN(4), .SETTLE(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
    kmap_scanner #(.N_IN(4), .SETTLE(3)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3));

    logic [1:0] mode1;
    logic       glitch3;
    int         n_chk  = 0;
    int         n_pass = 0;

    // 0: 4-input XOR, 1: constant 0, 2: a&b, 3: majority(a,b,c)
    function automatic logic kmap_fn(input logic [1:0] mode, input logic [3:0] m);
        case (mode)
            2'd0:    return ^m;
            2'd1:    return 1'b0;
            2'd2:    return m[3] & m[2];
            default: return (m[3] & m[2]) | (m[3] & m[1]) | (m[2] & m[1]);
        endcase
    endfunction

    always_comb bus1.f_in = kmap_fn(mode1, bus1.abcd_out);
    always_comb bus3.f_in = kmap_fn(2'd2, bus3.abcd_out) | glitch3;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges after the accept edge until done is seen; -1 on timeout.
    task automatic wait_done1(output int lat);
        lat = -1;
        for (int n = 1; n <= 200; n++) begin
            tick();
            if (bus1.done) begin
                lat = n;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int errs;
        int seen;

        rst          = 1'b1;
        bus1.start   = 1'b0;
        bus1.expected = '0;
        bus3.start   = 1'b0;
        bus3.expected = '0;
        mode1        = 2'd0;
        glitch3      = 1'b0;
        tick();
        tick();
        check("rst_abcd",  bus1.abcd_out, 0);
        check("rst_busy",  bus1.busy,     0);
        check("rst_done",  bus1.done,     0);
        check("rst_truth", bus1.truth,    0);
        check("rst_ones",  bus1.ones_cnt, 0);
        check("rst_match", bus1.match,    0);
        check("rst3_truth", bus3.truth,   0);
        rst = 1'b0;
        tick();

        // XOR parity block
        mode1 = 2'd0;
        bus1.expected = 16'h6996;
        bus1.start = 1'b1;
        tick();
        bus1.start = 1'b0;
        check("xor_busy_after_accept", bus1.busy, 1);
        wait_done1(lat);
        check("xor_latency", lat, 32);
        check("xor_truth", bus1.truth, 16'h6996);
        check("xor_ones",  bus1.ones_cnt, 8);
        check("xor_match", bus1.match, 1);
        check("xor_busy_in_done", bus1.busy, 1);
        tick();
        check("xor_done_width", bus1.done, 0);
        check("xor_busy_after", bus1.busy, 0);
        check("xor_abcd_idle",  bus1.abcd_out, 0);
        check("xor_truth_hold", bus1.truth, 16'h6996);
        check("xor_match_hold", bus1.match, 1);

        // Constant-0 block, step pattern and accept-edge clearing
        mode1 = 2'd1;
        bus1.expected = 16'h0001;
        bus1.start = 1'b1;
        tick();
        bus1.start = 1'b0;
        check("clr_truth", bus1.truth, 0);
        check("clr_ones",  bus1.ones_cnt, 0);
        check("clr_match", bus1.match, 0);
        errs = 0;
        for (int m = 0; m < 16; m++) begin
            if (bus1.abcd_out !== 4'(m)) errs++;
            tick();
            if (bus1.abcd_out !== 4'(m)) errs++;
            tick();
        end
        check("zero_abcd_steps", errs, 0);
        check("zero_done",  bus1.done, 1);
        check("zero_truth", bus1.truth, 0);
        check("zero_ones",  bus1.ones_cnt, 0);
        check("zero_match", bus1.match, 0);
        tick();

        // SETTLE=3, a&b, glitches on f_in only during APPLY
        bus3.expected = 16'hF000;
        bus3.start = 1'b1;
        tick();
        bus3.start = 1'b0;
        lat = -1;
        for (int n = 1; n <= 300; n++) begin
            glitch3 = ((n - 1) % 4 == 1);
            tick();
            if (bus3.done) begin
                lat = n;
                break;
            end
        end
        glitch3 = 1'b0;
        check("s3_latency", lat, 64);
        check("s3_truth", bus3.truth, 16'hF000);
        check("s3_ones",  bus3.ones_cnt, 4);
        check("s3_match", bus3.match, 1);

        // start held high through a whole scan
        mode1 = 2'd0;
        bus1.expected = 16'h6996;
        bus1.start = 1'b1;
        tick();
        wait_done1(lat);
        check("held_latency", lat, 32);
        tick();
        check("held_idle_busy", bus1.busy, 0);
        check("held_idle_done", bus1.done, 0);
        tick();
        check("held_reaccept_busy",  bus1.busy, 1);
        check("held_reaccept_truth", bus1.truth, 0);
        bus1.start = 1'b0;
        wait_done1(lat);
        check("held_second_latency", lat, 32);
        check("held_second_truth", bus1.truth, 16'h6996);
        tick();

        // reset mid-scan
        bus1.start = 1'b1;
        tick();
        bus1.start = 1'b0;
        for (int i = 0; i < 100 && bus1.abcd_out != 4'd5; i++) tick();
        check("mid_reach5", bus1.abcd_out, 5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_abcd",  bus1.abcd_out, 0);
        check("mid_rst_busy",  bus1.busy, 0);
        check("mid_rst_done",  bus1.done, 0);
        check("mid_rst_truth", bus1.truth, 0);
        check("mid_rst_ones",  bus1.ones_cnt, 0);
        check("mid_rst_match", bus1.match, 0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus1.done || bus1.busy) seen++;
        end
        check("mid_rst_quiet", seen, 0);

        // majority(a,b,c) after the reset
        mode1 = 2'd3;
        bus1.expected = 16'hFCC0;
        bus1.start = 1'b1;
        tick();
        bus1.start = 1'b0;
        wait_done1(lat);
        check("maj_latency", lat, 32);
        check("maj_truth", bus1.truth, 16'hFCC0);
        check("maj_ones",  bus1.ones_cnt, 8);
        check("maj_match", bus1.match, 1);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
